// File: rtl/twiddle_pkg.sv
// Shared types and constants for the FFT twiddle multiplier: W_32^m table
// (cos, -sin) in Q1.8 and the half-frame state encoding.
package twiddle_pkg;

  localparam int TW_FRAC  = 8;
  localparam int TW_TAB_W = 10;
  localparam int TW_TAB_N = 16;

  typedef enum logic {PASS, ROT} half_state_e;

  typedef logic signed [TW_TAB_W-1:0] tw_t;

  // Real part: round(256*cos(2*pi*m/32))
  localparam tw_t TW_COS [TW_TAB_N] = '{
    10'sd256,  10'sd251,  10'sd237,  10'sd213,
    10'sd181,  10'sd142,  10'sd98,   10'sd50,
    10'sd0,   -10'sd50,  -10'sd98,  -10'sd142,
   -10'sd181, -10'sd213, -10'sd237, -10'sd251
  };

  // Imag part: round(-256*sin(2*pi*m/32))
  localparam tw_t TW_NSIN [TW_TAB_N] = '{
    10'sd0,   -10'sd50,  -10'sd98,  -10'sd142,
   -10'sd181, -10'sd213, -10'sd237, -10'sd251,
   -10'sd256, -10'sd251, -10'sd237, -10'sd213,
   -10'sd181, -10'sd142, -10'sd98,  -10'sd50
  };

endpackage

// File: rtl/twiddle_rom.sv
// Registered twiddle lookup: table index in, (c, d) = (cos, -sin) out one
// cycle later. Holds its output when en is low.
module twiddle_rom
  import twiddle_pkg::*;
#(
  parameter int TW_W = 10
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic [3:0]             idx,
  output logic signed [TW_W-1:0] c,
  output logic signed [TW_W-1:0] d
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c <= '0;
      d <= '0;
    end else if (en) begin
      c <= TW_W'(TW_COS[idx]);
      d <= TW_W'(TW_NSIN[idx]);
    end
  end

endmodule

// File: rtl/twiddle_mul.sv
// Complex twiddle multiplier after the radix-2 butterfly: SUM half passes
// (W^0), DIFF half sample k is rotated by W_N^k. 3-cycle fixed latency.
// Build option TWMUL_SAT_EN: saturate results and raise sticky ovf; otherwise wrap.
module twiddle_mul
  import twiddle_pkg::*;
#(
  parameter int IN_W     = 13,
  parameter int OUT_W    = 13,
  parameter int TW_W     = 10,
  parameter int NUM_PAIR = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    din_valid,
  input  logic signed [IN_W-1:0]  din_re,
  input  logic signed [IN_W-1:0]  din_im,
  output logic                    dout_valid,
  output logic signed [OUT_W-1:0] dout_re,
  output logic signed [OUT_W-1:0] dout_im,
  output logic                    frame_done,
  output logic                    ovf
);

  localparam int CNT_W  = $clog2(NUM_PAIR);
  localparam int STEP   = 16 / NUM_PAIR;
  localparam int PROD_W = IN_W + TW_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int SH_W   = SUM_W - TW_FRAC;

  localparam logic signed [SUM_W-1:0] RND    = SUM_W'(1 << (TW_FRAC - 1));
  localparam logic signed [SH_W-1:0]  SH_MAX = SH_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SH_W-1:0]  SH_MIN = ~SH_MAX;

  half_state_e      state, state_nxt;
  logic [CNT_W-1:0] sample_cnt, cnt_nxt;
  logic             last_sample;
  logic             rot_last;
  logic [3:0]       tw_idx;

  // Half-frame sequencing; din_valid gaps freeze both state and count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= PASS;
      sample_cnt <= '0;
    end else begin
      state      <= state_nxt;
      sample_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = sample_cnt;
    last_sample = (sample_cnt == CNT_W'(NUM_PAIR - 1));
    if (din_valid) begin
      if (last_sample) begin
        cnt_nxt   = '0;
        state_nxt = (state == PASS) ? ROT : PASS;
      end else begin
        cnt_nxt = sample_cnt + CNT_W'(1);
      end
    end
  end

  assign rot_last = din_valid && (state == ROT) && last_sample;
  assign tw_idx   = (state == ROT) ? 4'(32'(sample_cnt) * STEP) : 4'd0;

  // S1: input and twiddle registers
  logic                   v1, fd1;
  logic signed [IN_W-1:0] a1, b1;
  logic signed [TW_W-1:0] c1, d1;

  twiddle_rom #(.TW_W(TW_W)) u_rom (
    .clk  (clk),
    .rstn (rstn),
    .en   (din_valid),
    .idx  (tw_idx),
    .c    (c1),
    .d    (d1)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1  <= 1'b0;
      fd1 <= 1'b0;
      a1  <= '0;
      b1  <= '0;
    end else begin
      v1  <= din_valid;
      fd1 <= rot_last;
      if (din_valid) begin
        a1 <= din_re;
        b1 <= din_im;
      end
    end
  end

  // S2: partial products
  logic                     v2, fd2;
  logic signed [PROD_W-1:0] p_ac, p_bd, p_ad, p_bc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2   <= 1'b0;
      fd2  <= 1'b0;
      p_ac <= '0;
      p_bd <= '0;
      p_ad <= '0;
      p_bc <= '0;
    end else begin
      v2  <= v1;
      fd2 <= fd1;
      if (v1) begin
        p_ac <= a1 * c1;
        p_bd <= b1 * d1;
        p_ad <= a1 * d1;
        p_bc <= b1 * c1;
      end
    end
  end

  // S3: combine, round half-up, drop fraction bits, fit to OUT_W
  logic signed [SUM_W-1:0] re_sum, im_sum, rnd_re, rnd_im;
  logic signed [SH_W-1:0]  re_sh, im_sh;
  logic [OUT_W-1:0]        re_out, im_out;
  logic                    clip;
  logic                    unused_bits;

  always_comb begin
    re_sum = {p_ac[PROD_W-1], p_ac} - {p_bd[PROD_W-1], p_bd};
    im_sum = {p_ad[PROD_W-1], p_ad} + {p_bc[PROD_W-1], p_bc};
    rnd_re = re_sum + RND;
    rnd_im = im_sum + RND;
    re_sh  = rnd_re[SUM_W-1:TW_FRAC];
    im_sh  = rnd_im[SUM_W-1:TW_FRAC];
  end

`ifdef TWMUL_SAT_EN
  function automatic logic [OUT_W:0] sat(input logic signed [SH_W-1:0] v);
    if (v > SH_MAX)      return {1'b1, SH_MAX[OUT_W-1:0]};
    else if (v < SH_MIN) return {1'b1, SH_MIN[OUT_W-1:0]};
    else                 return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] re_sat, im_sat;

  always_comb begin
    re_sat = sat(re_sh);
    im_sat = sat(im_sh);
    re_out = re_sat[OUT_W-1:0];
    im_out = im_sat[OUT_W-1:0];
    clip   = re_sat[OUT_W] | im_sat[OUT_W];
  end

  assign unused_bits = ^{rnd_re[TW_FRAC-1:0], rnd_im[TW_FRAC-1:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          ovf <= 1'b0;
    else if (v2 && clip) ovf <= 1'b1;
  end
`else
  always_comb begin
    re_out = re_sh[OUT_W-1:0];
    im_out = im_sh[OUT_W-1:0];
    clip   = 1'b0;
  end

  assign unused_bits = ^{rnd_re[TW_FRAC-1:0], rnd_im[TW_FRAC-1:0],
                         re_sh[SH_W-1:OUT_W], im_sh[SH_W-1:OUT_W], clip};
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
    end else begin
      dout_valid <= v2;
      frame_done <= fd2;
      if (v2) begin
        dout_re <= re_out;
        dout_im <= im_out;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_mul.sv
// Directed bench for twiddle_mul: NUM_PAIR=16 and NUM_PAIR=4 instances,
// table-driven frames plus saturation and mid-frame reset sequences.
module tb_twiddle_mul;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic               v16 = 1'b0, v4 = 1'b0;
  logic signed [12:0] re16 = '0, im16 = '0, re4 = '0, im4 = '0;
  logic               dv16, dv4, fd16, fd4, ovf16, ovf4;
  logic signed [12:0] dre16, dim16, dre4, dim4;

  twiddle_mul #(.NUM_PAIR(16)) u16 (
    .clk(clk), .rstn(rstn), .din_valid(v16), .din_re(re16), .din_im(im16),
    .dout_valid(dv16), .dout_re(dre16), .dout_im(dim16),
    .frame_done(fd16), .ovf(ovf16)
  );

  twiddle_mul #(.NUM_PAIR(4)) u4 (
    .clk(clk), .rstn(rstn), .din_valid(v4), .din_re(re4), .din_im(im4),
    .dout_valid(dv4), .dout_re(dre4), .dout_im(dim4),
    .frame_done(fd4), .ovf(ovf4)
  );

  typedef struct {int pos; int in_re; int in_im; int ex_re; int ex_im;} vec_t;
  typedef struct {int re; int im; bit fd; int cyc;} out_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fd16_cnt = 0;
  out_t q16[$], q4[$];
  int   in_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv16) q16.push_back('{int'(dre16), int'(dim16), fd16, cyc});
    if (dv4)  q4.push_back('{int'(dre4), int'(dim4), fd4, cyc});
    if (fd16) fd16_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive16(input int re, input int im, input bit v);
    @(negedge clk);
    v16 = v; re16 = 13'(re); im16 = 13'(im);
    if (v) in_cyc.push_back(cyc);
  endtask

  task automatic drive4(input int re, input int im, input bit v);
    @(negedge clk);
    v4 = v; re4 = 13'(re); im4 = 13'(im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v16 = 1'b0; v4 = 1'b0;
    end
  endtask

  vec_t tab16[9];
  vec_t tab4[4];
  int   f_in_re[32], f_in_im[32], f_ex_re[32], f_ex_im[32];

  task automatic run_frame16(input string name, input bit gaps);
    int fd_before;
    int n;
    q16.delete();
    in_cyc.delete();
    fd_before = fd16_cnt;
    for (int p = 0; p < 32; p++) begin
      drive16(f_in_re[p], f_in_im[p], 1'b1);
      if (gaps && (p % 2 == 1)) drive16(0, 0, 1'b0);
    end
    idle(6);
    chk({name, " count"}, q16.size(), 32);
    n = (q16.size() < 32) ? q16.size() : 32;
    for (int p = 0; p < n; p++) begin
      chk($sformatf("%s re[%0d]", name, p), q16[p].re, f_ex_re[p]);
      chk($sformatf("%s im[%0d]", name, p), q16[p].im, f_ex_im[p]);
    end
    if (n == 32) chk({name, " fd on last"}, int'(q16[31].fd), 1);
    chk({name, " fd pulses"}, fd16_cnt - fd_before, 1);
    if (n > 0 && in_cyc.size() > 0)
      chk({name, " latency"}, q16[0].cyc - in_cyc[0], 3);
  endtask

  initial begin
    int sat_re, sat_im, sat_ovf, fd_keep;

    tab16[0] = '{0,    100,    50,   100,   50};
    tab16[1] = '{1,     -7,     3,    -7,    3};
    tab16[2] = '{15, -4096,  4095, -4096, 4095};
    tab16[3] = '{16,    33,   -12,    33,  -12};
    tab16[4] = '{17,     1,     0,     1,    0};
    tab16[5] = '{20,   256,     0,   181, -181};
    tab16[6] = '{24,   100,    50,    50, -100};
    tab16[7] = '{28,     0,   256,   181, -181};
    tab16[8] = '{31,     2,     0,    -2,    0};

    tab4[0] = '{0,  -7,   3,  -7,    3};
    tab4[1] = '{5, 256,   0, 181, -181};
    tab4[2] = '{6,  20, -30, -30,  -20};
    tab4[3] = '{7,   0, 256, 181, -181};

    for (int p = 0; p < 32; p++) begin
      f_in_re[p] = 0; f_in_im[p] = 0; f_ex_re[p] = 0; f_ex_im[p] = 0;
    end
    foreach (tab16[i]) begin
      f_in_re[tab16[i].pos] = tab16[i].in_re;
      f_in_im[tab16[i].pos] = tab16[i].in_im;
      f_ex_re[tab16[i].pos] = tab16[i].ex_re;
      f_ex_im[tab16[i].pos] = tab16[i].ex_im;
    end

    repeat (2) @(negedge clk);
    chk("reset dout_valid", int'(dv16), 0);
    chk("reset dout_re", int'(dre16), 0);
    chk("reset dout_im", int'(dim16), 0);
    chk("reset frame_done", int'(fd16), 0);
    chk("reset ovf", int'(ovf16), 0);
    rstn = 1'b1;
    idle(2);

    run_frame16("gapless", 1'b0);
    run_frame16("gapped", 1'b1);
    chk("ovf after frames", int'(ovf16), 0);

    // NUM_PAIR=4 instance: ROT k maps to table index 4*k
    q4.delete();
    for (int p = 0; p < 8; p++) begin
      int ir, ii;
      ir = 0; ii = 0;
      foreach (tab4[i]) if (tab4[i].pos == p) begin ir = tab4[i].in_re; ii = tab4[i].in_im; end
      drive4(ir, ii, 1'b1);
    end
    idle(6);
    chk("np4 count", q4.size(), 8);
    if (q4.size() == 8) begin
      foreach (tab4[i]) begin
        chk($sformatf("np4 re[%0d]", tab4[i].pos), q4[tab4[i].pos].re, tab4[i].ex_re);
        chk($sformatf("np4 im[%0d]", tab4[i].pos), q4[tab4[i].pos].im, tab4[i].ex_im);
      end
      chk("np4 fd on last", int'(q4[7].fd), 1);
    end

`ifdef TWMUL_SAT_EN
    sat_re = -4096; sat_im = 0; sat_ovf = 1;
`else
    sat_re = 2400;  sat_im = 0; sat_ovf = 0;
`endif
    q16.delete();
    for (int p = 0; p < 23; p++) begin
      if (p == 20) drive16(-4096, -4096, 1'b1);
      else         drive16(0, 0, 1'b1);
    end
    idle(6);
    chk("sat count", q16.size(), 23);
    if (q16.size() == 23) begin
      chk("sat re", q16[20].re, sat_re);
      chk("sat im", q16[20].im, sat_im);
      chk("post-sat zero re", q16[21].re, 0);
    end
    chk("ovf set", int'(ovf16), sat_ovf);
    idle(8);
    chk("ovf held", int'(ovf16), sat_ovf);

    // Reset while ROT samples are still in flight
    q16.delete();
    fd_keep = fd16_cnt;
    drive16(5, 5, 1'b1);
    drive16(5, 5, 1'b1);
    @(negedge clk);
    v16 = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst dout_valid", int'(dv16), 0);
    chk("rst ovf", int'(ovf16), 0);
    idle(2);
    rstn = 1'b1;
    idle(5);
    chk("rst discarded", q16.size(), 0);
    chk("rst no frame_done", fd16_cnt - fd_keep, 0);
    drive16(100, 50, 1'b1);
    drive16(100, 50, 1'b1);
    idle(6);
    chk("restart count", q16.size(), 2);
    if (q16.size() == 2) begin
      chk("restart re0", q16[0].re, 100);
      chk("restart im0", q16[0].im, 50);
      chk("restart re1", q16[1].re, 100);
      chk("restart im1", q16[1].im, 50);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
